aes_round_engine: RTL and testbench

AES_ROUND_ENGINE -- requirements
Module: aes_round_engine

---
 rtl/aes_round_engine.sv | 162 ++++++++++++++++
 tb/tb_aes_round_engine.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_engine.sv
// Iterative AES encryption engine: one round per clock. It takes a plaintext
// block and a fully expanded key schedule, and returns the ciphertext after NR
// round edges. A three-state FSM (IDLE/RUN/DONE) handles the ready/valid
// handshake on both sides, and a consumed result can overlap with the next
// acceptance.
module aes_round_engine #(
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          in_data,
    input  logic [128*(NR+1)-1:0] key,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_data,
    output logic                  busy,
    output logic [3:0]            round_cnt
);

    localparam int         KW   = 128 * (NR + 1);
    localparam logic [3:0] LAST = 4'(NR);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Only the three AES key sizes have a defined round count.
    generate
        if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
            $error("aes_round_engine: NR must be 10, 12 or 14");
        end
    endgenerate

    // Forward S-box. Entry 0 is in the MSBs, so byte b is at bit offset 8*(255-b).
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes -> ShiftRows -> (MixColumns unless last). The round key is added by the caller.
    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sub_byte(s[127-8*i -: 8]);
        end
        // Byte index is row + 4*column. Row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (last) begin
                res[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                res[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                       a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                       a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                       xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return res;
    endfunction

    logic [1:0]   fsm;
    logic [127:0] aes_state;
    logic [KW-1:0] key_q;
    logic [127:0] rk_arr [NR+1];
    logic [127:0] round_out;
    logic         accept;

    // Slice the latched key schedule into round keys. rk0 comes from the MSBs.
    generate
        for (genvar g = 0; g <= NR; g++) begin : g_rk
            assign rk_arr[g] = key_q[KW-1-128*g -: 128];
        end
    endgenerate

    assign in_ready  = (fsm == S_IDLE) || ((fsm == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (fsm == S_RUN);
    assign out_data  = aes_state;
    assign round_out = round_fn(aes_state, round_cnt == LAST);

    // Control and datapath state: load on acceptance, one round per edge in RUN, hold in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= S_IDLE;
            aes_state <= '0;
            key_q     <= '0;
            round_cnt <= 4'd0;
            out_valid <= 1'b0;
        end else if (accept) begin
            // Accepting in DONE also retires the previous result on this same edge.
            key_q     <= key;
            aes_state <= in_data ^ key[KW-1 -: 128];
            round_cnt <= 4'd1;
            fsm       <= S_RUN;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                S_RUN: begin
                    aes_state <= round_out ^ rk_arr[round_cnt];
                    if (round_cnt == LAST) begin
                        fsm       <= S_DONE;
                        out_valid <= 1'b1;
                        round_cnt <= 4'd0;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        fsm       <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                S_IDLE: begin
                end
                default: begin
                    fsm       <= S_IDLE;
                    out_valid <= 1'b0;
                    round_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine. It runs FIPS-197 known-answer vectors for
// NR=10/12/14 and checks backpressure, back-to-back acceptance, input changes
// after acceptance, reset mid-run, and randomized blocks. The randomized blocks
// are compared against an AES model that works on the state matrix.
module tb_aes_round_engine;

    logic clk;
    logic rst;
    logic [127:0] in_data;

    logic          in_valid10, in_ready10, out_valid10, out_ready10, busy10;
    logic [1407:0] key10;
    logic [127:0]  out_data10;
    logic [3:0]    round_cnt10;

    logic          in_valid12, in_ready12, out_valid12, busy12;
    logic [1663:0] key12;
    logic [127:0]  out_data12;
    logic [3:0]    round_cnt12;

    logic          in_valid14, in_ready14, out_valid14, busy14;
    logic [1919:0] key14;
    logic [127:0]  out_data14;
    logic [3:0]    round_cnt14;

    logic          out_ready_hi;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] rk_m [15];

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT10  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KAT12  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] KAT14  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_round_engine #(.NR(10)) u_dut10 (
        .clk(clk), .rst(rst), .in_valid(in_valid10), .in_ready(in_ready10),
        .in_data(in_data), .key(key10), .out_valid(out_valid10),
        .out_ready(out_ready10), .out_data(out_data10), .busy(busy10),
        .round_cnt(round_cnt10));

    aes_round_engine #(.NR(12)) u_dut12 (
        .clk(clk), .rst(rst), .in_valid(in_valid12), .in_ready(in_ready12),
        .in_data(in_data), .key(key12), .out_valid(out_valid12),
        .out_ready(out_ready_hi), .out_data(out_data12), .busy(busy12),
        .round_cnt(round_cnt12));

    aes_round_engine #(.NR(14)) u_dut14 (
        .clk(clk), .rst(rst), .in_valid(in_valid14), .in_ready(in_ready14),
        .in_data(in_data), .key(key14), .out_valid(out_valid14),
        .out_ready(out_ready_hi), .out_data(out_data14), .busy(busy14),
        .round_cnt(round_cnt14));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic check_v(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic init_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gf_mul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    // FIPS-197 key expansion; the cipher key is left-aligned in k. Fills rk_m[0..nk+6].
    task automatic expand_key(input logic [255:0] k, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nr;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = k[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                    rcon = gf_mul(rcon, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic rand_sched();
        for (int i = 0; i < 15; i++) rk_m[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    function automatic logic [1919:0] pack_sched(input int nr);
        logic [1919:0] v;
        v = '0;
        for (int i = 0; i <= nr; i++) v[1919-128*i -: 128] = rk_m[i];
        return v;
    endfunction

    // Encrypt using the 4x4 state matrix s[row][col] and the round keys in rk_m.
    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input int nr);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ rk_m[0][127-8*(4*c+r) -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox_m[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rnd < nr)
                        s[r][c] = gf_mul(8'h02, t[r][c]) ^ gf_mul(8'h03, t[(r+1)%4][c])
                                ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    else
                        s[r][c] = t[r][c];
                    s[r][c] = s[r][c] ^ rk_m[rnd][127-8*(4*c+r) -: 8];
                end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = s[r][c];
        return res;
    endfunction

    // ---------------- stimulus helpers (entered just after a negedge) ----------------
    task automatic send10(input logic [127:0] pt, input logic [1407:0] ks);
        bit ok;
        ok = 1'b0;
        in_data    = pt;
        key10      = ks;
        in_valid10 = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            #1;
            ok = in_ready10;
            @(negedge clk);
        end
        in_valid10 = 1'b0;
        check_i("accept10", int'(ok), 1);
    endtask

    task automatic wait_out10(input int max, output int lat);
        lat = -1;
        for (int k = 1; k <= max && lat < 0; k++) begin
            @(negedge clk);
            if (out_valid10) lat = k;
        end
    endtask

    initial begin
        logic [1919:0] sched;
        logic [127:0]  pt, expv;
        int            lat, lat12, lat14, d, seen;
        logic [127:0]  cap12, cap14;
        bit            found;

        init_sbox();
        rst = 1'b1;
        in_data = '0;
        in_valid10 = 1'b0; in_valid12 = 1'b0; in_valid14 = 1'b0;
        out_ready10 = 1'b1; out_ready_hi = 1'b1;
        key10 = '0; key12 = '0; key14 = '0;
        repeat (3) @(negedge clk);

        check_i("rst_out_valid", int'(out_valid10), 0);
        check_i("rst_busy", int'(busy10), 0);
        check_i("rst_round_cnt", int'(round_cnt10), 0);
        check_v("rst_out_data", out_data10, 128'h0);
        check_i("rst_in_ready", int'(in_ready10), 1);

        expand_key(256'h000102030405060708090a0b0c0d0e0f << 128, 4);
        sched = pack_sched(10);
        key10 = sched[1919 -: 1408];
        expand_key(256'h000102030405060708090a0b0c0d0e0f1011121314151617 << 64, 6);
        sched = pack_sched(12);
        key12 = sched[1919 -: 1664];
        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        sched = pack_sched(14);
        key14 = sched;

        // NR=10 known answer: accepted on the first edge after reset release, in_valid kept high.
        rst = 1'b0;
        in_data = PT;
        in_valid10 = 1'b1;
        out_ready10 = 1'b0;
        #1;
        check_i("first_edge_ready", int'(in_ready10), 1);
        @(negedge clk);
        check_i("acc_round_cnt", int'(round_cnt10), 1);
        check_i("acc_busy", int'(busy10), 1);
        check_i("acc_out_valid", int'(out_valid10), 0);
        in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < 1408 / 32; i++) key10[32*i +: 32] = $urandom();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check_i("run_round_cnt", int'(round_cnt10), (k < 10) ? k + 1 : 0);
            check_i("run_busy", int'(busy10), (k < 10) ? 1 : 0);
            check_i("run_out_valid", int'(out_valid10), (k >= 10) ? 1 : 0);
        end
        check_v("kat10_data", out_data10, KAT10);

        // Backpressure: hold for 20 cycles with in_valid still asserted.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_v("hold_data", out_data10, KAT10);
            check_i("hold_out_valid", int'(out_valid10), 1);
            check_i("hold_in_ready", int'(in_ready10), 0);
            check_i("hold_busy", int'(busy10), 0);
        end

        // Consume and accept the next block on the same edge.
        rand_sched();
        pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        expv = model_encrypt(pt, 10);
        sched = pack_sched(10);
        key10 = sched[1919 -: 1408];
        in_data = pt;
        out_ready10 = 1'b1;
        #1;
        check_i("b2b_in_ready", int'(in_ready10), 1);
        @(negedge clk);
        in_valid10 = 1'b0;
        check_i("b2b_out_valid", int'(out_valid10), 0);
        check_i("b2b_busy", int'(busy10), 1);
        check_i("b2b_round_cnt", int'(round_cnt10), 1);
        wait_out10(30, lat);
        check_i("b2b_latency", lat, 10);
        check_v("b2b_data", out_data10, expv);
        @(negedge clk);
        check_i("consume_out_valid", int'(out_valid10), 0);
        check_i("consume_in_ready", int'(in_ready10), 1);
        check_i("consume_busy", int'(busy10), 0);

        // NR=12 and NR=14 known answers.
        in_data = PT;
        in_valid12 = 1'b1;
        in_valid14 = 1'b1;
        @(negedge clk);
        in_valid12 = 1'b0;
        in_valid14 = 1'b0;
        lat12 = -1; lat14 = -1; cap12 = '0; cap14 = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid12 && lat12 < 0) begin lat12 = k; cap12 = out_data12; end
            if (out_valid14 && lat14 < 0) begin lat14 = k; cap14 = out_data14; end
        end
        check_i("kat12_latency", lat12, 12);
        check_v("kat12_data", cap12, KAT12);
        check_i("kat14_latency", lat14, 14);
        check_v("kat14_data", cap14, KAT14);

        // Randomized blocks with random backpressure.
        for (int n = 0; n < 8; n++) begin
            rand_sched();
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            expv = model_encrypt(pt, 10);
            sched = pack_sched(10);
            out_ready10 = 1'b0;
            send10(pt, sched[1919 -: 1408]);
            wait_out10(30, lat);
            check_i("rand_latency", lat, 10);
            check_v("rand_data", out_data10, expv);
            d = $urandom_range(0, 3);
            for (int i = 0; i < d; i++) begin
                @(negedge clk);
                check_v("rand_hold_data", out_data10, expv);
            end
            out_ready10 = 1'b1;
            @(negedge clk);
            check_i("rand_consumed", int'(out_valid10), 0);
        end

        // Reset in the middle of a block.
        rand_sched();
        pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        sched = pack_sched(10);
        send10(pt, sched[1919 -: 1408]);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (round_cnt10 == 4'd5) found = 1'b1;
            else @(negedge clk);
        end
        check_i("reach_round5", int'(found), 1);
        rst = 1'b1;
        #1;
        check_i("mid_rst_out_valid", int'(out_valid10), 0);
        check_i("mid_rst_busy", int'(busy10), 0);
        check_i("mid_rst_round_cnt", int'(round_cnt10), 0);
        check_v("mid_rst_out_data", out_data10, 128'h0);
        check_i("mid_rst_in_ready", int'(in_ready10), 1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid10) seen++;
        end
        check_i("no_valid_after_rst", seen, 0);

        rand_sched();
        pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        expv = model_encrypt(pt, 10);
        sched = pack_sched(10);
        send10(pt, sched[1919 -: 1408]);
        wait_out10(30, lat);
        check_i("post_rst_latency", lat, 10);
        check_v("post_rst_data", out_data10, expv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
